// File: rtl/fe_be_decoupling_queue.sv
// Decoupling queue between front end and back end: one enqueue per cycle,
// up to deq_width_p oldest entries presented for in-order consumption.
module fe_be_decoupling_queue #(
    parameter int width_p             = 32,
    parameter int els_p               = 32,
    parameter int deq_width_p         = 2,
    parameter int almost_full_slack_p = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               flush_i,
    input  logic                               v_i,
    input  logic [width_p-1:0]                 data_i,
    output logic                               ready_o,
    output logic [deq_width_p-1:0]             v_o,
    output logic [deq_width_p*width_p-1:0]     data_o,
    input  logic [$clog2(deq_width_p+1)-1:0]   yumi_cnt_i,
    output logic [$clog2(els_p+1)-1:0]         count_o,
    output logic                               almost_full_o
);

    localparam int ptr_w_lp     = $clog2(els_p);
    localparam int cnt_w_lp     = $clog2(els_p + 1);
    localparam int cnt_ext_w_lp = cnt_w_lp + 1;

    logic [width_p-1:0]      mem [els_p];
    logic [ptr_w_lp-1:0]     rd_ptr;
    logic [ptr_w_lp-1:0]     wr_ptr;
    logic [ptr_w_lp-1:0]     rd_ptr_next;
    logic [cnt_w_lp-1:0]     count;
    logic [cnt_w_lp-1:0]     count_next;
    logic [cnt_ext_w_lp-1:0] count_sum;
    logic [cnt_w_lp-1:0]     yumi_limit;
    logic                    enq;
    logic                    enq_write;

    // Readiness looks only at the registered count, so a full queue refuses
    // an entry even when a dequeue happens in the same cycle.
    assign ready_o   = (count < cnt_w_lp'(els_p));
    assign enq       = v_i & ready_o;
    assign enq_write = enq & ~flush_i;

    assign count_sum   = {1'b0, count} + cnt_ext_w_lp'(enq) - cnt_ext_w_lp'(yumi_cnt_i);
    assign count_next  = cnt_w_lp'(count_sum);
    assign rd_ptr_next = rd_ptr + ptr_w_lp'(yumi_cnt_i);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + ptr_w_lp'(1);
            end
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
        end
    end

    // Storage is never reset; validity is carried entirely by count.
    always_ff @(posedge clk_i) begin
        if (enq_write) begin
            mem[wr_ptr] <= data_i;
        end
    end

    for (genvar k = 0; k < deq_width_p; k++) begin : g_slot
        logic [ptr_w_lp-1:0] idx;
        assign idx                           = rd_ptr + ptr_w_lp'(k);
        assign data_o[k*width_p +: width_p]  = mem[idx];
        assign v_o[k]                        = (count > cnt_w_lp'(k));
    end

    assign count_o       = count;
    assign almost_full_o = (count >= cnt_w_lp'(els_p - almost_full_slack_p));

    // The consumer may only take slots that are currently shown as valid.
    assign yumi_limit = (count > cnt_w_lp'(deq_width_p)) ? cnt_w_lp'(deq_width_p) : count;

    a_yumi_legal : assert property (@(posedge clk_i) disable iff (reset_i)
        cnt_w_lp'(yumi_cnt_i) <= yumi_limit);

endmodule

// File: tb/tb_fe_be_decoupling_queue.sv
// Scoreboard bench for fe_be_decoupling_queue with els_p=8, deq_width_p=2,
// almost_full_slack_p=2.
module tb_fe_be_decoupling_queue;

    localparam int W     = 8;
    localparam int ELS   = 8;
    localparam int DEQ   = 2;
    localparam int SLACK = 2;

    logic           clk_i = 1'b0;
    logic           reset_i;
    logic           flush_i;
    logic           v_i;
    logic [W-1:0]   data_i;
    logic           ready_o;
    logic [DEQ-1:0] v_o;
    logic [DEQ*W-1:0] data_o;
    logic [1:0]     yumi_cnt_i;
    logic [3:0]     count_o;
    logic           almost_full_o;

    int tests_run   = 0;
    int fail_count  = 0;
    int model_count = 0;
    logic [W-1:0] exp_q[$];

    fe_be_decoupling_queue #(
        .width_p(W),
        .els_p(ELS),
        .deq_width_p(DEQ),
        .almost_full_slack_p(SLACK)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .flush_i(flush_i),
        .v_i(v_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .v_o(v_o),
        .data_o(data_o),
        .yumi_cnt_i(yumi_cnt_i),
        .count_o(count_o),
        .almost_full_o(almost_full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Status outputs against the occupancy the bench expects after the last edge.
    task automatic checkOutput();
        check("count_o", 32'(count_o), 32'(model_count));
        check("v_o", 32'(v_o), 32'({model_count > 1, model_count > 0}));
        check("ready_o", 32'(ready_o), 32'(model_count < ELS));
        check("almost_full_o", 32'(almost_full_o), 32'(model_count >= ELS - SLACK));
    endtask

    task automatic checkSlot0(input string name, input logic [W-1:0] expected);
        check(name, 32'(data_o[W-1:0]), 32'(expected));
    endtask

    // Drive one cycle of inputs; accepted entries go onto the scoreboard now,
    // and the monitor retires them when the bench consumes them.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input int yumi, input logic flush);
        v_i        = v;
        data_i     = d;
        yumi_cnt_i = 2'(yumi);
        flush_i    = flush;
        if (flush) begin
            exp_q.delete();
            model_count = 0;
        end else begin
            if (v && model_count < ELS) begin
                exp_q.push_back(d);
                model_count++;
            end
            model_count -= yumi;
        end
        @(posedge clk_i);
        #1;
        v_i        = 1'b0;
        yumi_cnt_i = 2'd0;
        flush_i    = 1'b0;
        checkOutput();
    endtask

    // Monitor: every consumed slot must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (!reset_i && !flush_i) begin
            for (int k = 0; k < int'(yumi_cnt_i); k++) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    fail_count++;
                    $display("[TB] FAIL deq_underflow: slot %0d consumed 0x%0h, expected nothing", k, data_o[k*W +: W]);
                end else begin
                    check($sformatf("deq_slot%0d", k), 32'(data_o[k*W +: W]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sent;
        int guard;
        int maxy;
        int y;

        reset_i    = 1'b1;
        flush_i    = 1'b0;
        v_i        = 1'b0;
        data_i     = '0;
        yumi_cnt_i = 2'd0;
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput();
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;

        $display("[TB] fill");
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, W'(8'h10 + i), 0, 1'b0);
        applyStimulus(1'b1, 8'h18, 0, 1'b0);
        check("full_count", 32'(count_o), 32'd8);

        $display("[TB] dual dequeue");
        repeat (4) applyStimulus(1'b0, 8'h00, 2, 1'b0);
        check("drained_v_o", 32'(v_o), 32'd0);

        $display("[TB] wrap-around");
        sent  = 0;
        guard = 0;
        while ((sent < 20 || model_count > 0) && guard < 400) begin
            maxy = (model_count < DEQ) ? model_count : DEQ;
            y    = int'($urandom_range(maxy, 0));
            if (sent < 20 && model_count < ELS) begin
                applyStimulus(1'b1, W'(sent), y, 1'b0);
                sent++;
            end else begin
                applyStimulus(sent < 20, W'(sent), y, 1'b0);
            end
            guard++;
        end
        check("wrap_sent", 32'(sent), 32'd20);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] partial slot");
        applyStimulus(1'b1, 8'h31, 0, 1'b0);
        applyStimulus(1'b1, 8'h32, 1, 1'b0);
        checkSlot0("partial_slot0", 8'h32);
        check("partial_v_o", 32'(v_o), 32'd1);
        applyStimulus(1'b0, 8'h00, 1, 1'b0);

        $display("[TB] flush collision");
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, W'(8'h41 + i), 0, 1'b0);
        applyStimulus(1'b1, 8'hEE, 1, 1'b1);
        check("flush_count", 32'(count_o), 32'd0);
        applyStimulus(1'b1, 8'hAA, 0, 1'b0);
        checkSlot0("post_flush_slot0", 8'hAA);
        check("post_flush_v_o", 32'(v_o), 32'd1);
        applyStimulus(1'b0, 8'h00, 1, 1'b0);

        $display("[TB] reset mid-run");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, W'(8'h61 + i), 0, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_v_o", 32'(v_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_almost_full", 32'(almost_full_o), 32'd0);
        exp_q.delete();
        model_count = 0;
        @(negedge clk_i);
        reset_i = 1'b0;
        @(posedge clk_i);
        #1;
        applyStimulus(1'b1, 8'h5A, 0, 1'b0);
        checkSlot0("post_reset_slot0", 8'h5A);
        applyStimulus(1'b0, 8'h00, 1, 1'b0);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
